// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
// Groups the two handshakes of the FIFO stream reader:
//   FIFO read port : r_e (read enable), buf_out (read data), buf_empty
//   Output stream  : m_data, m_valid, m_ready
// Modports:
//   master - the reader itself (drives r_e and the stream, receives FIFO data
//            and downstream ready)
//   slave  - the environment (FIFO plus downstream consumer)
// Parameter DSIZE is the data word width and must match the FIFO.
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DSIZE = 8
);
    logic             r_e;
    logic [DSIZE-1:0] buf_out;
    logic             buf_empty;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output r_e, m_data, m_valid,
        input  buf_out, buf_empty, m_ready
    );

    modport slave (
        input  r_e, m_data, m_valid,
        output buf_out, buf_empty, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-side controller for the synchronous FIFO. Drains xfer_len words from
// the FIFO read port and presents them on a valid/ready stream. A 2-entry
// output queue absorbs the one-cycle FIFO read latency so the stream can run
// at one word per clock without backpressure.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   start      - single-cycle transfer request, honoured only in IDLE
//   xfer_len   - transfer length in words, sampled on an accepted start
//   busy       - high while in RUN or DRAIN
//   done       - one-cycle completion pulse
//   words_left - words not yet accepted downstream
//   stall_cnt  - (RD_STALL_CNT_EN only) cycles lost to an empty FIFO
//   bus        - fifo_stream_reader_if.master (FIFO read port + stream)
//
// Optional feature macro: RD_STALL_CNT_EN
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DSIZE = 8,
    parameter int LW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LW-1:0]        xfer_len,
    output logic                 busy,
    output logic                 done,
    output logic [LW-1:0]        words_left,
`ifdef RD_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    fifo_stream_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       occ;
    logic             rd_pend;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic [LW-1:0]    issue_left;
    logic [2:0]       inflight;
    logic             pop;
    logic             push;
    logic             credit;
    logic             accept;

    // Words already buffered plus the one still coming back from the FIFO.
    assign inflight = {1'b0, occ} + {2'b00, rd_pend};
    assign pop      = bus.m_valid && bus.m_ready;
    assign push     = rd_pend;
    // A slot is free now, or one is being freed by a pop this cycle.
    assign credit   = (inflight < 3'd2) || pop;
    assign accept   = (state == IDLE) && start;

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (xfer_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.r_e && (issue_left == LW'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_pend && (occ == 2'd0) && (words_left == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.r_e = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        bus.r_e = (state == RUN) && !bus.buf_empty && (issue_left != '0) && credit;
        busy    = (state == RUN) || (state == DRAIN);
        done    = (state == DONE);
    end

    // Counters, read-pending flag and the 2-entry output queue. head_q is
    // always the oldest word; a word returning from the FIFO lands in head_q
    // when the queue is (or is becoming) empty, otherwise behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            occ        <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            issue_left <= '0;
            words_left <= '0;
        end else begin
            rd_pend <= bus.r_e;

            if (accept) begin
                issue_left <= xfer_len;
                words_left <= xfer_len;
            end else begin
                if (bus.r_e && (issue_left != '0)) begin
                    issue_left <= issue_left - LW'(1);
                end
                if (pop && (words_left != '0)) begin
                    words_left <= words_left - LW'(1);
                end
            end

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_q <= bus.buf_out;
                    end else begin
                        tail_q <= bus.buf_out;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= bus.buf_out;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= bus.buf_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RD_STALL_CNT_EN
    // Counts cycles where a read would have issued but the FIFO was empty.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && bus.buf_empty && (issue_left != '0) &&
                     credit && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    // The queue can never be asked to hold more than two words.
    assert property (@(posedge clk) disable iff (rst) inflight <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed self-checking bench for fifo_stream_reader. Contains a small
// behavioural synchronous FIFO (one-cycle read latency) feeding the reader,
// and a negedge monitor that records accepted stream words, done pulses and
// read enables.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] xfer_len;
    logic       busy;
    logic       done;
    logic [7:0] words_left;
`ifdef RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_stream_reader_if #(.DSIZE(8)) bus ();

    fifo_stream_reader #(.DSIZE(8), .LW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .xfer_len   (xfer_len),
        .busy       (busy),
        .done       (done),
        .words_left (words_left),
`ifdef RD_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO, reset by the same rst as the reader
    logic [7:0] fmem [16];
    logic [3:0] frd;
    logic [3:0] fwr;
    logic [4:0] fcount;
    logic [7:0] fbuf_out;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_fire;

    assign rd_fire       = bus.r_e && (fcount != 5'd0);
    assign bus.buf_empty = (fcount == 5'd0);
    assign bus.buf_out   = fbuf_out;

    always @(posedge clk) begin
        if (rst) begin
            frd      <= 4'd0;
            fwr      <= 4'd0;
            fcount   <= 5'd0;
            fbuf_out <= 8'd0;
        end else begin
            if (wr_en) begin
                fmem[fwr] <= wr_data;
                fwr       <= fwr + 4'd1;
            end
            if (rd_fire) begin
                fbuf_out <= fmem[frd];
                frd      <= frd + 4'd1;
            end
            fcount <= fcount + {4'd0, wr_en} - {4'd0, rd_fire};
        end
    end

    // Monitor
    logic [7:0] rx_q [$];
    int         done_cnt;
    int         re_cnt;
    int         re_empty_cnt;
    int         data_changed;
    logic       stall_mon;
    logic [7:0] hold_data;

    initial begin
        done_cnt     = 0;
        re_cnt       = 0;
        re_empty_cnt = 0;
        data_changed = 0;
        stall_mon    = 1'b0;
        hold_data    = 8'd0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
            if (bus.r_e) re_cnt++;
            if (bus.r_e && bus.buf_empty) re_empty_cnt++;
            if (done) done_cnt++;
            if (stall_mon && (!bus.m_valid || (bus.m_data !== hold_data))) data_changed++;
        end
    end

    int n_assert;
    int n_fail;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] len);
        start    = 1'b1;
        xfer_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic preload(input logic [7:0] words [], input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = words[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        int k;
        base = done_cnt;
        k    = 0;
        while ((done_cnt == base) && (k < budget)) begin
            tick();
            k++;
        end
        check_output({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        check_output({tag, "_rx_reached"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] words [], input int n);
        check_output({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check_output($sformatf("%s_word%0d", tag, i), 32'(rx_q[i]), 32'(words[i]));
        end
    endtask

    logic [15:0] re_bits;
    logic [15:0] mv_bits;
    logic [15:0] busy_bits;
    logic [15:0] done_bits;
    logic [7:0]  md [16];

    initial begin
        logic [7:0] t1 [] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D};
        logic [7:0] t2 [] = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h96, 8'h69};
        logic [7:0] t3 [] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] t5 [] = '{8'hE1, 8'h7E};
        logic [7:0] t6 [] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        int base_done;
        int base_re;

        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        xfer_len    = 8'd0;
        wr_en       = 1'b0;
        wr_data     = 8'd0;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check_output("rst_r_e", 32'(bus.r_e), 32'd0);
        check_output("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("rst_m_data", 32'(bus.m_data), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_words_left", 32'(words_left), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Test 1: five words, no backpressure, cycle-exact timing
        $display("[TB] test 1: streaming 5 words");
        preload(t1, 5);
        bus.m_ready = 1'b1;
        apply_stimulus(8'd5);
        re_bits = '0; mv_bits = '0; busy_bits = '0; done_bits = '0;
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            re_bits[c]   = bus.r_e;
            mv_bits[c]   = bus.m_valid;
            busy_bits[c] = busy;
            done_bits[c] = done;
            md[c]        = bus.m_data;
        end
        check_output("t1_r_e_pattern", 32'(re_bits), 32'h003E);
        check_output("t1_m_valid_pattern", 32'(mv_bits), 32'h00F8);
        check_output("t1_busy_pattern", 32'(busy_bits), 32'h01FE);
        check_output("t1_done_pattern", 32'(done_bits), 32'h0200);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("t1_m_data%0d", i), 32'(md[i+3]), 32'(t1[i]));
        end
        check_output("t1_words_left", 32'(words_left), 32'd0);
        tick();

        // Test 2: backpressure after the second accept
        $display("[TB] test 2: backpressure");
        rx_q.delete();
        preload(t2, 8);
        apply_stimulus(8'd8);
        wait_rx("t2_first2", 2, 20);
        bus.m_ready = 1'b0;
        hold_data   = bus.m_data;
        stall_mon   = 1'b1;
        repeat (6) tick();
        check_output("t2_stall_occ", 32'(dut.occ), 32'd2);
        check_output("t2_stall_r_e", 32'(bus.r_e), 32'd0);
        check_output("t2_stall_head", 32'(bus.m_data), 32'(t2[2]));
        check_output("t2_stall_words_left", 32'(words_left), 32'd6);
        stall_mon   = 1'b0;
        check_output("t2_data_stable", 32'(data_changed), 32'd0);
        bus.m_ready = 1'b1;
        wait_done("t2", 60);
        check_rx("t2", t2, 8);
        tick();

        // Test 3: FIFO starts empty and trickles in
        $display("[TB] test 3: empty FIFO trickle");
        rx_q.delete();
        re_empty_cnt = 0;
        base_re      = re_cnt;
        apply_stimulus(8'd4);
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick();
            wr_en   = 1'b1;
            wr_data = t3[i];
            tick();
            wr_en   = 1'b0;
        end
        wait_done("t3", 60);
        check_output("t3_r_e_while_empty", 32'(re_empty_cnt), 32'd0);
        check_output("t3_r_e_count", 32'(re_cnt - base_re), 32'd4);
        check_rx("t3", t3, 4);
`ifdef RD_STALL_CNT_EN
        check_output("t3_stall_cnt_nonzero", 32'(stall_cnt != 16'd0), 32'd1);
`endif
        tick();

        // Test 4: zero-length transfer
        $display("[TB] test 4: zero length");
        base_re = re_cnt;
        apply_stimulus(8'd0);
        @(negedge clk);
        check_output("t4_done", 32'(done), 32'd1);
        check_output("t4_busy", 32'(busy), 32'd0);
        check_output("t4_r_e", 32'(bus.r_e), 32'd0);
        @(negedge clk);
        check_output("t4_done_cleared", 32'(done), 32'd0);
        check_output("t4_r_e_count", 32'(re_cnt - base_re), 32'd0);
        tick();

        // Test 5: reset in the middle of a transfer
        $display("[TB] test 5: mid-transfer reset");
        rx_q.delete();
        preload(t2, 8);
        apply_stimulus(8'd8);
        wait_rx("t5_first3", 3, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_output("t5_r_e", 32'(bus.r_e), 32'd0);
        check_output("t5_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("t5_m_data", 32'(bus.m_data), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        check_output("t5_done", 32'(done), 32'd0);
        check_output("t5_words_left", 32'(words_left), 32'd0);
        tick();
        rx_q.delete();
        preload(t5, 2);
        apply_stimulus(8'd2);
        wait_done("t5", 30);
        check_rx("t5", t5, 2);
        check_output("t5_final_words_left", 32'(words_left), 32'd0);
        tick();

        // Test 6: start while busy is ignored
        $display("[TB] test 6: start while busy");
        rx_q.delete();
        base_done = done_cnt;
        preload(t6, 4);
        apply_stimulus(8'd4);
        tick();
        check_output("t6_busy_before_restart", 32'(busy), 32'd1);
        apply_stimulus(8'd9);
        wait_done("t6", 30);
        repeat (12) tick();
        check_output("t6_done_pulses", 32'(done_cnt - base_done), 32'd1);
        check_output("t6_busy_after", 32'(busy), 32'd0);
        check_output("t6_words_left", 32'(words_left), 32'd0);
        check_rx("t6", t6, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side controller for the team's synchronous FIFO. It drains a programmed number of words through the FIFO read port (r_e/buf_out/buf_empty) and presents them on a valid/ready stream. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so throughput is one word per clock under no backpressure. It sits between the FIFO and any downstream consumer, as the counterpart to the write-side producer.

Parameters:
DSIZE, 8, data word width; must match the FIFO DSIZE.
LW, 8, width of the transfer-length and words-left counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a transfer; honoured only in IDLE
xfer_len  in  LW  number of words to transfer; sampled on an accepted start
busy  out  1  high in RUN and DRAIN
done  out  1  single-cycle pulse when the transfer completes
buf_empty  in  1  FIFO empty flag
buf_out  in  DSIZE  FIFO read data
r_e  out  1  FIFO read enable
m_data  out  DSIZE  stream data (head of the output buffer)
m_valid  out  1  stream valid
m_ready  in  1  stream ready from the consumer
words_left  out  LW  words not yet accepted downstream

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high. It is sampled only at the clk rising edge.
- Reset values:
  - r_e=0, m_valid=0, m_data=0, busy=0, done=0, words_left=0.
  - Output buffer occupancy occ=0, rd_pend=0, state=IDLE.
  - An in-flight read is discarded (the FIFO is reset by the same rst).
- FIFO read contract: if r_e=1 in cycle N, the word is on buf_out in cycle N+1. The block captures it at the end of cycle N+1. rd_pend is a register equal to the previous cycle's r_e.
- r_e is combinational and is asserted only when all of the following hold:
  - state=RUN
  - buf_empty=0
  - issue_left>0
  - (occ+rd_pend<2) or (m_valid and m_ready)
- r_e is never asserted while buf_empty=1.
- Invariant: occ+rd_pend<=2, checked every cycle.
- Output buffer:
  - 2-entry in-order queue. m_valid = (occ!=0). m_data = head entry.
  - Push and pop can occur in the same cycle.
  - While m_valid=1 and m_ready=0, m_data holds stable.
- Counters (LW bits):
  - issue_left is loaded from xfer_len on start and decrements on each r_e.
  - words_left is loaded from xfer_len on start and decrements on each m_valid and m_ready.
  - Neither counter wraps below 0.
- State machine:
  - IDLE: on start with xfer_len!=0, go to RUN. On start with xfer_len=0, go to DONE. Otherwise hold.
  - RUN: when the final r_e issues (issue_left goes 1 to 0), go to DRAIN.
  - DRAIN: when rd_pend=0, occ=0 and words_left=0, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. xfer_len is not re-sampled.
- Steady-state throughput with m_ready held 1 is one word per cycle. First m_valid appears 2 cycles after the first r_e cycle.
- rst asserted mid-transfer wins over all other activity. Everything returns to reset values on the next edge.

Optional Feature:
Macro RD_STALL_CNT_EN.
- When defined: adds output stall_cnt [15:0]. It is cleared on rst and on an accepted start. It increments (saturating at 16'hFFFF) each cycle where state=RUN, buf_empty=1 and the credit condition would otherwise allow r_e.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then preload FIFO with 8'h24,8'h81,8'h09,8'h63,8'h0D. Hold m_ready=1 and start with xfer_len=5.
   -> r_e high for 5 consecutive cycles.
   -> m_data 24,81,09,63,0D on consecutive cycles, first one 2 cycles after the first r_e.
   -> done pulses once, then words_left=0 and busy=0.
2. Preload 8 words, start xfer_len=8, drop m_ready to 0 for 6 cycles after the 2nd accept.
   -> r_e stops with occ=2.
   -> m_data is stable throughout.
   -> all 8 words arrive in order with no duplicates.
3. Start xfer_len=4 with the FIFO empty. Write 4 words one every third cycle.
   -> r_e is never high while buf_empty=1.
   -> 4 words are output in order.
   -> stall_cnt>0 when RD_STALL_CNT_EN is defined.
4. Start with xfer_len=0.
   -> state goes straight to DONE.
   -> done is high in the next cycle.
   -> r_e stays 0 and busy stays 0.
5. Start xfer_len=8 and assert rst for one cycle after 3 words are accepted.
   -> all outputs are 0 on the next cycle.
   -> after the FIFO is refilled, a new start with xfer_len=2 completes normally.
6. Assert start with xfer_len=9 while busy during a len=4 transfer.
   -> it is ignored.
   -> exactly 4 words are output and a single done pulse is seen.
